// File: rtl/fru_pla_cfg_loader_if.sv
// Configuration stream interface for the FRU PLA configuration loader.
//   CfgStart : one-cycle pulse that begins or restarts a load (master -> slave)
//   CfgValid : CfgData holds a word                          (master -> slave)
//   CfgData  : configuration or checksum word                (master -> slave)
//   CfgReady : loader accepts a word this cycle              (slave -> master)
interface fru_pla_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              CfgStart;
  logic              CfgValid;
  logic [WORD_W-1:0] CfgData;
  logic              CfgReady;

  modport master (output CfgStart, output CfgValid, output CfgData, input  CfgReady);
  modport slave  (input  CfgStart, input  CfgValid, input  CfgData, output CfgReady);
endinterface

// File: rtl/fru_pla_cfg_loader.sv
// Configuration controller for the segmented FRU PLA.
// Assembles a word-serial configuration stream in a shadow register, checks a
// trailing XOR checksum and commits the shadow image to the active
// configuration in one edge. The PLA only ever sees checked images.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   cfg          : configuration stream (slave side of fru_pla_cfg_loader_if)
//   PlaCfg       : active configuration driving all segments
//   PlaCfgValid  : PlaCfg holds a committed, checked image
//   CfgDone      : one-cycle pulse after a commit
//   CfgError     : sticky checksum error, cleared by the next CfgStart
//   CfgBusy      : load in progress
module fru_pla_cfg_loader #(
  parameter int OUTPUT_SIZE  = 4,
  parameter int SEGMENT_SIZE = 2,
  parameter int MINTERMS     = 4,
  parameter int WORD_W       = 8,
  localparam int SEG_BITS    = MINTERMS * (2 * SEGMENT_SIZE) + MINTERMS,
  localparam int CFG_BITS    = OUTPUT_SIZE * SEG_BITS,
  localparam int NUM_WORDS   = (CFG_BITS + WORD_W - 1) / WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fru_pla_cfg_loader_if.slave cfg,
  output logic [CFG_BITS-1:0] PlaCfg,
  output logic                PlaCfgValid,
  output logic                CfgDone,
  output logic                CfgError,
  output logic                CfgBusy
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int PAD_W = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHK
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_xor;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_placfg;
  logic                r_placfg_valid;
  logic                r_done;
  logic                r_error;
  logic                r_busy;
  logic                r_ready;

  logic [PAD_W-1:0]    w_pad;
  logic [CFG_BITS-1:0] w_shadow_nxt;
  logic                w_last_word;

  // Shadow update is built on a word-aligned padded copy so the final word
  // can be written whole; any bits beyond CFG_BITS simply fall off.
  always_comb begin
    w_pad                 = '0;
    w_pad[CFG_BITS-1:0]   = r_shadow;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_pad[k*WORD_W +: WORD_W] = cfg.CfgData;
      end
    end
    w_shadow_nxt = w_pad[CFG_BITS-1:0];
  end

  assign w_last_word = (r_cnt == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_xor          <= '0;
      r_shadow       <= '0;
      r_placfg       <= '0;
      r_placfg_valid <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_busy         <= 1'b0;
      r_ready        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A start pulse wins over any word presented on the same edge.
      if (cfg.CfgStart) begin
        r_state <= LOAD;
        r_cnt   <= '0;
        r_xor   <= '0;
        r_error <= 1'b0;
        r_busy  <= 1'b1;
        r_ready <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
          LOAD: begin
            if (cfg.CfgValid) begin
              r_shadow <= w_shadow_nxt;
              r_xor    <= r_xor ^ cfg.CfgData;
              r_cnt    <= r_cnt + 1'b1;
              if (w_last_word) begin
                r_state <= CHK;
              end
            end
          end
          CHK: begin
            if (cfg.CfgValid) begin
              if (cfg.CfgData == r_xor) begin
                r_placfg       <= r_shadow;
                r_placfg_valid <= 1'b1;
                r_done         <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg.CfgReady = r_ready;
  assign PlaCfg       = r_placfg;
  assign PlaCfgValid  = r_placfg_valid;
  assign CfgDone      = r_done;
  assign CfgError     = r_error;
  assign CfgBusy      = r_busy;

endmodule

// File: tb/tb_fru_pla_cfg_loader.sv
// Directed bench for fru_pla_cfg_loader with a scoreboard of expected
// commit/error outcomes.
module tb_fru_pla_cfg_loader;

  localparam int WORD_W   = 8;
  localparam int CFG_BITS = 80;
  localparam int NW       = 10;

  typedef struct {
    logic                good;
    logic [CFG_BITS-1:0] cfg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fru_pla_cfg_loader_if #(.WORD_W(WORD_W)) bus ();

  logic [CFG_BITS-1:0] PlaCfg;
  logic                PlaCfgValid;
  logic                CfgDone;
  logic                CfgError;
  logic                CfgBusy;

  fru_pla_cfg_loader #(
    .OUTPUT_SIZE (4),
    .SEGMENT_SIZE(2),
    .MINTERMS    (4),
    .WORD_W      (WORD_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (bus),
    .PlaCfg     (PlaCfg),
    .PlaCfgValid(PlaCfgValid),
    .CfgDone    (CfgDone),
    .CfgError   (CfgError),
    .CfgBusy    (CfgBusy)
  );

  int n_pass  = 0;
  int n_total = 0;

  exp_t                q[$];
  logic [CFG_BITS-1:0] m_cfg   = '0;
  logic                m_valid = 1'b0;

  task automatic chk(input string tag, input logic [CFG_BITS-1:0] obs, input logic [CFG_BITS-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one word and hold it until a handshake edge (bounded).
  task automatic send(input logic [7:0] d, input int gap);
    logic acc;
    logic rdy;
    acc = 1'b0;
    bus.CfgValid = 1'b1;
    bus.CfgData  = d;
    for (int i = 0; i < 16 && !acc; i++) begin
      rdy = bus.CfgReady;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    chk("word_accepted", CFG_BITS'(acc), CFG_BITS'(1));
    bus.CfgValid = 1'b0;
    bus.CfgData  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse(input logic v, input logic [7:0] d);
    bus.CfgStart = 1'b1;
    bus.CfgValid = v;
    bus.CfgData  = d;
    @(posedge clk);
    #1;
    bus.CfgStart = 1'b0;
    bus.CfgValid = 1'b0;
    chk("start_busy",  CFG_BITS'(CfgBusy),      CFG_BITS'(1));
    chk("start_ready", CFG_BITS'(bus.CfgReady), CFG_BITS'(1));
    chk("start_err",   CFG_BITS'(CfgError),     CFG_BITS'(0));
  endtask

  // Send NW words plus a checksum; push the expected outcome and check it
  // on the cycle following the checksum edge.
  task automatic body(input logic [7:0] w[NW], input logic [7:0] cks, input int gap);
    logic [7:0]          x;
    logic [CFG_BITS-1:0] img;
    exp_t                e;
    x   = '0;
    img = '0;
    for (int k = 0; k < NW; k++) begin
      send(w[k], gap);
      x = x ^ w[k];
      img[k*8 +: 8] = w[k];
    end
    e.good = (cks === x);
    e.cfg  = e.good ? img : m_cfg;
    if (e.good) begin
      m_cfg   = img;
      m_valid = 1'b1;
    end
    q.push_back(e);
    send(cks, 0);
    e = q.pop_front();
    chk("done_pulse",  CFG_BITS'(CfgDone),      CFG_BITS'(e.good));
    chk("error_flag",  CFG_BITS'(CfgError),     CFG_BITS'(!e.good));
    chk("placfg",      PlaCfg,                  e.cfg);
    chk("placfg_vld",  CFG_BITS'(PlaCfgValid),  CFG_BITS'(m_valid));
    chk("busy_end",    CFG_BITS'(CfgBusy),      CFG_BITS'(0));
    chk("ready_end",   CFG_BITS'(bus.CfgReady), CFG_BITS'(0));
    @(posedge clk);
    #1;
    chk("done_single", CFG_BITS'(CfgDone),      CFG_BITS'(0));
    chk("error_stick", CFG_BITS'(CfgError),     CFG_BITS'(!e.good));
  endtask

  initial begin
    logic [7:0]          w[NW];
    logic [CFG_BITS-1:0] first_img;

    bus.CfgStart = 1'b0;
    bus.CfgValid = 1'b0;
    bus.CfgData  = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_placfg", PlaCfg,                  '0);
    chk("rst_valid",  CFG_BITS'(PlaCfgValid),  CFG_BITS'(0));
    chk("rst_done",   CFG_BITS'(CfgDone),      CFG_BITS'(0));
    chk("rst_error",  CFG_BITS'(CfgError),     CFG_BITS'(0));
    chk("rst_busy",   CFG_BITS'(CfgBusy),      CFG_BITS'(0));
    chk("rst_ready",  CFG_BITS'(bus.CfgReady), CFG_BITS'(0));

    // Default good load 0x01..0x0A, checksum 0x0B
    for (int k = 0; k < NW; k++) w[k] = 8'(k + 1);
    start_pulse(1'b0, 8'h00);
    body(w, 8'h0B, 0);
    chk("t1_lo", CFG_BITS'(PlaCfg[7:0]),   CFG_BITS'(8'h01));
    chk("t1_hi", CFG_BITS'(PlaCfg[79:72]), CFG_BITS'(8'h0A));
    first_img = m_cfg;

    // Bad checksum: 0xFF x10 with checksum 0x01
    for (int k = 0; k < NW; k++) w[k] = 8'hFF;
    start_pulse(1'b0, 8'h00);
    body(w, 8'h01, 0);
    chk("t2_retained", PlaCfg, first_img);

    // Idle hygiene: valid data while idle is ignored
    bus.CfgValid = 1'b1;
    bus.CfgData  = 8'h5A;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_ready",  CFG_BITS'(bus.CfgReady), CFG_BITS'(0));
      chk("idle_busy",   CFG_BITS'(CfgBusy),      CFG_BITS'(0));
      chk("idle_placfg", PlaCfg,                  first_img);
      chk("idle_error",  CFG_BITS'(CfgError),     CFG_BITS'(1));
    end
    bus.CfgValid = 1'b0;

    // Valid gaps; start coincides with a valid word in IDLE (ignored)
    for (int k = 0; k < NW; k++) w[k] = 8'(k + 1);
    start_pulse(1'b1, 8'h99);
    body(w, 8'h0B, 3);
    chk("t3_same", PlaCfg, first_img);

    // Abort: 5 words, restart together with a valid word, then 0xA5 x10
    start_pulse(1'b0, 8'h00);
    for (int k = 0; k < 5; k++) send(8'(8'h10 + k), 0);
    bus.CfgStart = 1'b1;
    bus.CfgValid = 1'b1;
    bus.CfgData  = 8'h77;
    @(posedge clk);
    #1;
    bus.CfgStart = 1'b0;
    bus.CfgValid = 1'b0;
    chk("abort_busy", CFG_BITS'(CfgBusy), CFG_BITS'(1));
    for (int k = 0; k < NW; k++) w[k] = 8'hA5;
    body(w, 8'h00, 0);
    chk("t4_a5", PlaCfg, {10{8'hA5}});

    // Reset mid-load after word 6
    start_pulse(1'b0, 8'h00);
    for (int k = 0; k < 7; k++) send(8'(8'h30 + k), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_cfg   = '0;
    m_valid = 1'b0;
    chk("mrst_placfg", PlaCfg,                  '0);
    chk("mrst_valid",  CFG_BITS'(PlaCfgValid),  CFG_BITS'(0));
    chk("mrst_busy",   CFG_BITS'(CfgBusy),      CFG_BITS'(0));
    chk("mrst_ready",  CFG_BITS'(bus.CfgReady), CFG_BITS'(0));
    chk("mrst_error",  CFG_BITS'(CfgError),     CFG_BITS'(0));
    begin
      logic [7:0] x;
      x = '0;
      for (int k = 0; k < NW; k++) begin
        w[k] = 8'($urandom);
        x    = x ^ w[k];
      end
      start_pulse(1'b0, 8'h00);
      body(w, x, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fru_pla_cfg_loader.md
Name: fru_pla_cfg_loader

Overview:
- Configuration controller for the segmented FRU PLA.
- Accepts a word-serial configuration stream over a valid/ready handshake and assembles it in a shadow register.
- Verifies a trailing XOR checksum, then atomically commits the shadow image to the active configuration that drives every segment's minterm-select and OR-plane bits.
- Sits between the patch-programming interface and the PLA array. The PLA never sees a partially written configuration.

Parameters:
- OUTPUT_SIZE, 4, number of FruSelect outputs (one segment PLA each).
- SEGMENT_SIZE, 2, triggers feeding one segment.
- MINTERMS, 4, minterms per segment.
- WORD_W, 8, configuration word width.
- SEG_BITS, MINTERMS*(2*SEGMENT_SIZE)+MINTERMS, derived: per-minterm true/complement enables plus OR-plane enables.
- CFG_BITS, OUTPUT_SIZE*SEG_BITS, derived (default 80).
- NUM_WORDS, ceil(CFG_BITS/WORD_W), derived (default 10).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- CfgStart  input  1  one-cycle pulse: begin or restart a load.
- CfgValid  input  1  CfgData valid.
- CfgData  input  WORD_W  configuration or checksum word.
- CfgReady  output  1  loader accepts a word this cycle.
- PlaCfg  output  CFG_BITS  active configuration to PLA segments.
- PlaCfgValid  output  1  PlaCfg holds a committed, checked image.
- CfgDone  output  1  one-cycle pulse: commit occurred.
- CfgError  output  1  sticky checksum error, cleared by the next CfgStart.
- CfgBusy  output  1  load in progress.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE.
  - PlaCfg=0, PlaCfgValid=0, CfgDone=0, CfgError=0, CfgBusy=0, CfgReady=0.
  - Word counter=0, running XOR=0, shadow=0.
  - Reset mid-load discards everything.
- Word acceptance: only on CfgValid & CfgReady at a clk edge. CfgData may change freely when not accepted.
- IDLE:
  - CfgReady=0.
  - CfgStart=1 -> LOAD. On that edge: counter=0, XOR=0, CfgError=0, CfgBusy=1.
  - PlaCfg and PlaCfgValid are unchanged.
- LOAD:
  - CfgReady=1.
  - Each accepted word k (0..NUM_WORDS-1) is written to shadow bits [k*WORD_W +: WORD_W]. Bits beyond CFG_BITS in the final word are dropped.
  - XOR ^= CfgData; counter++.
  - After word NUM_WORDS-1 is accepted -> CHK.
- CHK:
  - CfgReady=1. Expects exactly one checksum word.
  - If the accepted word equals XOR: PlaCfg<=shadow and PlaCfgValid<=1 on the same edge; CfgDone=1 for the next cycle.
  - If it does not match: CfgError<=1. PlaCfg and PlaCfgValid are unchanged, so the previous good image is retained.
  - Either case -> IDLE with CfgBusy=0.
- CfgStart in LOAD or CHK: abort and restart. Counter and XOR are cleared, state=LOAD, and no commit happens. CfgStart has priority over a simultaneously accepted word, which is discarded.
- CfgStart in IDLE in the same cycle as CfgValid=1: the data is ignored because CfgReady=0.
- Commit is atomic: all CFG_BITS update on one edge. Latency from checksum acceptance to new PlaCfg is 1 edge.
- CfgDone and CfgError are never both asserted for the same load.
- Counter width is clog2(NUM_WORDS+1). There is no wrap-around, because the state changes at the terminal count.
- Shadow content is never visible on PlaCfg except through a good commit.

Test Plan:
- Reset, then a default-parameter load:
  - Stimulus: CfgStart, words 0x01..0x0A back-to-back, checksum 0x0B (XOR of 0x01..0x0A).
  - Required: CfgDone pulses once, one cycle after the checksum edge. PlaCfgValid=1. PlaCfg[7:0]=0x01 and PlaCfg[79:72]=0x0A.
- Bad checksum:
  - Stimulus: after a good load, reload 0xFF x10 with checksum 0x01 (expected 0x00).
  - Required: CfgError=1, CfgDone never pulses, PlaCfg still holds the previous image, PlaCfgValid=1.
- Valid gaps:
  - Stimulus: the good load with CfgValid deasserted for 3 cycles between every word.
  - Required: identical final PlaCfg. Counter advances only on handshakes.
- Abort:
  - Stimulus: CfgStart, 5 words, CfgStart asserted together with a valid word, then a full good load of 0xA5 x10 with checksum 0x00.
  - Required: PlaCfg is all 0xA5. The word coincident with the restart is discarded.
- Reset mid-load:
  - Stimulus: rst_n=0 for one cycle after word 6.
  - Required: all outputs 0, state IDLE. A subsequent good load commits normally.
- Idle hygiene:
  - Stimulus: CfgValid=1 with data while IDLE.
  - Required: CfgReady=0, counter, XOR and PlaCfg unchanged. CfgError clears on the next CfgStart.
